// File: rtl/key_debounce_pkg.sv
// Shared constants and FSM encodings for the pushbutton debouncer and related pin inputs.
package key_debounce_pkg;

  localparam int unsigned BOARD_CLK_HZ            = 27_000_000;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 270_000;
  localparam int unsigned DEFAULT_LONG_CYCLES     = 27_000_000;

  localparam logic [1:0] ST_UP        = 2'b00;
  localparam logic [1:0] ST_WAIT_DOWN = 2'b01;
  localparam logic [1:0] ST_DOWN      = 2'b10;
  localparam logic [1:0] ST_WAIT_UP   = 2'b11;

  typedef enum logic [1:0] {
    S_UP        = ST_UP,
    S_WAIT_DOWN = ST_WAIT_DOWN,
    S_DOWN      = ST_DOWN,
    S_WAIT_UP   = ST_WAIT_UP
  } state_e;

endpackage

// File: rtl/key_debounce_sync2.sv
// Two-flop synchronizer for asynchronous pin inputs; resets to RST_VAL.
module sync2 #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/key_debounce.sv
// Pushbutton debouncer: sync, polarity-normalise, 4-state debounce FSM with press/release pulses.
// Optional long-press pulse output enabled by defining KEY_DEBOUNCE_LONGPRESS_EN.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = 20,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
  input  logic clock,
  input  logic rst_n,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release
`ifdef KEY_DEBOUNCE_LONGPRESS_EN
  ,
  output logic key_long
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Elaboration-time sanity: counter must hold DEBOUNCE_CYCLES-1 and never wrap.
  if ((DEBOUNCE_CYCLES < 2) || (((64'(DEBOUNCE_CYCLES) - 64'd1) >> CNT_W) != 64'd0)
      || (LONG_CYCLES < 2)) begin : g_param_err
    $error("key_debounce: invalid DEBOUNCE_CYCLES/CNT_W/LONG_CYCLES");
  end

  logic w_sync;
  logic w_key_s;

  sync2 #(
    .RST_VAL(ACTIVE_LOW)
  ) u_sync2 (
    .clock(clock),
    .rst_n(rst_n),
    .i_d  (key_in),
    .o_q  (w_sync)
  );

  assign w_key_s = ACTIVE_LOW ? ~w_sync : w_sync;

  state_e           r_state;
  state_e           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_level;
  logic             w_level_next;
  logic             r_press;
  logic             w_press_next;
  logic             r_release;
  logic             w_release_next;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_UP;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_level   <= w_level_next;
      r_press   <= w_press_next;
      r_release <= w_release_next;
    end
  end

  // Next state; any disagreeing sample restarts the stability count.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_level_next   = r_level;
    w_press_next   = 1'b0;
    w_release_next = 1'b0;
    unique case (r_state)
      S_UP: begin
        w_cnt_next = '0;
        if (w_key_s) begin
          w_state_next = S_WAIT_DOWN;
        end
      end
      S_WAIT_DOWN: begin
        if (!w_key_s) begin
          w_state_next = S_UP;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = S_DOWN;
          w_cnt_next   = '0;
          w_level_next = 1'b1;
          w_press_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_DOWN: begin
        w_cnt_next = '0;
        if (!w_key_s) begin
          w_state_next = S_WAIT_UP;
        end
      end
      S_WAIT_UP: begin
        if (w_key_s) begin
          w_state_next = S_DOWN;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next   = S_UP;
          w_cnt_next     = '0;
          w_level_next   = 1'b0;
          w_release_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_next = S_UP;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign key_level   = r_level;
  assign key_press   = r_press;
  assign key_release = r_release;

`ifdef KEY_DEBOUNCE_LONGPRESS_EN
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] r_hold;
  logic              r_long_done;
  logic              r_long;

  // Hold counter saturates; r_long_done keeps release bounces from re-firing within one press.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_hold      <= '0;
      r_long_done <= 1'b0;
      r_long      <= 1'b0;
    end else begin
      r_long <= 1'b0;
      if ((r_state == S_DOWN) && (w_state_next == S_DOWN)) begin
        if (r_hold == HOLD_LAST) begin
          if (!r_long_done) begin
            r_long      <= 1'b1;
            r_long_done <= 1'b1;
          end
        end else begin
          r_hold <= r_hold + HOLD_W'(1);
        end
      end else begin
        r_hold <= '0;
      end
      if (w_press_next) begin
        r_long_done <= 1'b0;
      end
    end
  end

  assign key_long = r_long;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: directed scenarios plus randomized key activity vs a run-length model.
module tb_key_debounce;

  localparam int unsigned DEB  = 8;
  localparam int unsigned LONG = 16;
  localparam int          LAT  = DEB + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_in = 1'b1;
  logic key_level;
  logic key_press;
  logic key_release;
`ifdef KEY_DEBOUNCE_LONGPRESS_EN
  logic key_long;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (4),
    .ACTIVE_LOW     (1'b1),
    .LONG_CYCLES    (LONG)
  ) dut (
    .clock      (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release)
`ifdef KEY_DEBOUNCE_LONGPRESS_EN
    ,
    .key_long   (key_long)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: pipe of two synced samples; the debounced level flips once the synced,
  // normalised input has disagreed with it for DEB+1 consecutive samples.
  logic m_p1 = 1'b0;
  logic m_p2 = 1'b0;
  logic m_level = 1'b0;
  logic m_press = 1'b0;
  logic m_release = 1'b0;
  int   m_run = 0;
  int   m_presses = 0;

  always begin
    logic ks;
    @(posedge clk);
    m_press   = 1'b0;
    m_release = 1'b0;
    if (!rst_n) begin
      m_p1 = 1'b0; m_p2 = 1'b0; m_level = 1'b0; m_run = 0;
    end else begin
      ks   = m_p2;
      m_p2 = m_p1;
      m_p1 = ~key_in;
      m_run = (ks != m_level) ? m_run + 1 : 0;
      if (m_run == int'(DEB) + 1) begin
        m_level   = ks;
        m_run     = 0;
        m_press   = ks;
        m_release = ~ks;
        if (ks) m_presses++;
      end
    end
    #2;
    check("level", 32'(key_level), 32'(m_level));
    check("press", 32'(key_press), 32'(m_press));
    check("release", 32'(key_release), 32'(m_release));
    check("press_and_release", 32'(key_press & key_release), 32'd0);
  end

  function automatic logic pulse(input int sel);
    case (sel)
      0: return key_press;
      1: return key_release;
`ifdef KEY_DEBOUNCE_LONGPRESS_EN
      2: return key_long;
`endif
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_pulse(input int sel, input int limit, output int edges);
    edges = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk); #1;
      if (pulse(sel)) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic run_cycles(input int n, output int np, output int nr, output int nl);
    np = 0; nr = 0; nl = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      np += int'(key_press);
      nr += int'(key_release);
      nl += int'(pulse(2));
    end
  endtask

  task automatic drive_key(input logic v, input int n, inout int np, inout int nr);
    int a, b, c;
    @(negedge clk); key_in = v;
    run_cycles(n, a, b, c);
    np += a; nr += b;
  endtask

  initial begin
    int e, np, nr, nl;
    // Reset with key released
    #1;
    check("rst_level", 32'(key_level), 32'd0);
    check("rst_press", 32'(key_press), 32'd0);
    check("rst_release", 32'(key_release), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_cycles(100, np, nr, nl);
    check("idle_pulses", 32'(np + nr), 32'd0);

    // Clean press and release
    @(negedge clk); key_in = 1'b0;
    wait_pulse(0, 40, e);
    check("press_latency", 32'(e), 32'(LAT));
    check("level_after_press", 32'(key_level), 32'd1);
    run_cycles(20, np, nr, nl);
    check("held_no_pulse", 32'(np + nr), 32'd0);
    @(negedge clk); key_in = 1'b1;
    wait_pulse(1, 40, e);
    check("release_latency", 32'(e), 32'(LAT));
    check("level_after_release", 32'(key_level), 32'd0);
    run_cycles(20, np, nr, nl);

    // Bounce: no commits, then a clean press
    np = 0; nr = 0;
    drive_key(1'b0, 5, np, nr);
    drive_key(1'b1, 2, np, nr);
    drive_key(1'b0, 5, np, nr);
    drive_key(1'b1, 20, np, nr);
    check("bounce_no_pulse", 32'(np + nr), 32'd0);
    check("bounce_level", 32'(key_level), 32'd0);
    @(negedge clk); key_in = 1'b0;
    wait_pulse(0, 40, e);
    check("bounce_press_latency", 32'(e), 32'(LAT));
    run_cycles(10, np, nr, nl);
    @(negedge clk); key_in = 1'b1;
    wait_pulse(1, 40, e);
    check("bounce_release_latency", 32'(e), 32'(LAT));
    run_cycles(15, np, nr, nl);

    // Reset mid-count discards partial count
    @(negedge clk); key_in = 1'b0;
    run_cycles(6, np, nr, nl);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    check("midrst_level", 32'(key_level), 32'd0);
    rst_n = 1'b1;
    wait_pulse(0, 40, e);
    check("midrst_press_latency", 32'(e), 32'(LAT));
    check("midrst_level_after", 32'(key_level), 32'd1);
    @(negedge clk); key_in = 1'b1;
    wait_pulse(1, 40, e);
    check("midrst_release_latency", 32'(e), 32'(LAT));
    run_cycles(15, np, nr, nl);

`ifdef KEY_DEBOUNCE_LONGPRESS_EN
    // Long hold: one key_long LONG cycles after the press
    @(negedge clk); key_in = 1'b0;
    wait_pulse(0, 40, e);
    check("long_press_latency", 32'(e), 32'(LAT));
    wait_pulse(2, 40, e);
    check("long_latency", 32'(e), 32'(LONG));
    run_cycles(24, np, nr, nl);
    check("long_once", 32'(nl), 32'd0);
    @(negedge clk); key_in = 1'b1;
    wait_pulse(1, 40, e);
    check("long_release_latency", 32'(e), 32'(LAT));
    // Short hold: no key_long
    @(negedge clk); key_in = 1'b0;
    wait_pulse(0, 40, e);
    check("short_press_latency", 32'(e), 32'(LAT));
    run_cycles(10, np, nr, nl);
    @(negedge clk); key_in = 1'b1;
    run_cycles(25, np, nr, nl);
    check("short_no_long", 32'(nl), 32'd0);
    check("short_release_count", 32'(nr), 32'd1);
`endif

    // Randomized activity with occasional resets; the model checks every cycle
    for (int b = 0; b < 250; b++) begin
      @(negedge clk);
      key_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 40) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      repeat ($urandom_range(1, 14)) @(negedge clk);
    end
    check("random_saw_presses", 32'(m_presses > 3), 32'd1);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 270_000, giving the required stable-input time in clocks (10 ms at 27 MHz).
REQ-002 The block SHALL have parameter CNT_W, default 20, giving the debounce counter width; it SHALL hold DEBOUNCE_CYCLES-1.
REQ-003 The block SHALL have parameter ACTIVE_LOW, default 1; when 1, a pressed key drives the pin low.
REQ-004 The block SHALL have parameter LONG_CYCLES, default 27_000_000, giving the hold time for a long press (used only under REQ-020).
REQ-005 The block SHALL have port clock, input, 1 bit: the single system clock, all logic on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port key_in, input, 1 bit: raw asynchronous pin from the pushbutton.
REQ-008 The block SHALL have port key_level, output, 1 bit: debounced pressed state, 1 = pressed.
REQ-009 The block SHALL have port key_press, output, 1 bit: one-cycle pulse on a committed press.
REQ-010 The block SHALL have port key_release, output, 1 bit: one-cycle pulse on a committed release.

Function
REQ-011 key_in SHALL pass through a 2-flop synchronizer, then be polarity-normalised to key_s (1 = pressed) per ACTIVE_LOW.
REQ-012 The FSM SHALL have states UP, WAIT_DOWN, DOWN and WAIT_UP, with counter cnt.
- UP: key_s=1 -> WAIT_DOWN with cnt=0.
- WAIT_DOWN: key_s=0 -> UP. Otherwise, if cnt==DEBOUNCE_CYCLES-1 -> DOWN; else cnt+1.
- DOWN: key_s=0 -> WAIT_UP with cnt=0.
- WAIT_UP: key_s=1 -> DOWN. Otherwise, if cnt==DEBOUNCE_CYCLES-1 -> UP; else cnt+1.
REQ-013 On the WAIT_DOWN->DOWN transition, key_level SHALL become 1 and key_press SHALL be 1 for exactly one cycle, both registered on the same edge.
REQ-014 On the WAIT_UP->UP transition, key_level SHALL become 0 and key_release SHALL be 1 for exactly one cycle.
REQ-015 Latency from the first stable key_in change to the pulse SHALL be exactly DEBOUNCE_CYCLES+3 rising edges.
REQ-016 Any glitch shorter than DEBOUNCE_CYCLES synced cycles SHALL produce no pulse and no change on key_level; a bounce SHALL restart the count from 0.
REQ-017 key_press and key_release SHALL never be asserted in the same cycle; two presses SHALL be separated by at least one key_release.
REQ-018 cnt SHALL never wrap; it is held at 0 in UP and DOWN.

Reset
REQ-019 While rst_n=0, the block SHALL asynchronously reset:
- synchronizer flops to the released level (1 if ACTIVE_LOW, else 0);
- FSM to UP, cnt=0;
- key_level, key_press and key_release to 0.
Reset mid-WAIT_DOWN SHALL discard the partial count; after release, a held key SHALL need a full DEBOUNCE_CYCLES again.

Configuration
REQ-020 With macro KEY_DEBOUNCE_LONGPRESS_EN defined, the block SHALL add output key_long (1 bit).
- A hold counter counts in DOWN.
- key_long SHALL pulse for one cycle when the hold reaches LONG_CYCLES, at most once per press.
- The hold counter clears on leaving DOWN and on reset; key_long resets to 0.
Without the macro, key_long and the hold counter SHALL not exist.

Structure
REQ-021 A shared package/include SHALL hold:
- board clock frequency constant (27_000_000);
- FSM state encodings (2-bit localparams);
- default DEBOUNCE_CYCLES and LONG_CYCLES.
REQ-022 The 2-flop synchronizer SHALL be a separate sub-module, sync2 (parameter RST_VAL), reusable by other pin inputs.

Verification (DEBOUNCE_CYCLES=8, ACTIVE_LOW=1)
REQ-023 Reset: rst_n=0 with key_in=1 -> all outputs 0; release rst_n with key_in held 1 for 100 cycles -> no pulse.
REQ-024 Clean press: key_in 1->0 at cycle 0 and held -> key_press=1 only at edge 11, key_level=1 from edge 11; later key_in 0->1 -> key_release exactly 11 edges after.
REQ-025 Bounce: key_in low 5, high 2, low 5, high -> no pulse; then low 20 -> one key_press, 11 edges after the last falling edge.
REQ-026 Reset mid-count: key_in low, rst_n pulsed low at cycle 6 -> no pulse until 11 edges after rst_n deasserts.
REQ-027 Long press (macro defined, LONG_CYCLES=16): hold 40 cycles -> key_press, then exactly one key_long 16 cycles later; no key_long if held only 10 cycles; build without the macro -> key_long port absent.
